// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the clocked ALU: queues operand/opcode commands, drives one at a
// time onto the ALU, holds it for LATENCY edges, then returns the result on valid/ready.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_op,
    input  logic [WIDTH-1:0]         alu_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    output logic [2:0]               out_op,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic [2:0]       r_mem_op [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [2:0]       r_out_op;

    logic w_push;
    logic w_pop;

    // in_ready depends only on the registered count, so neither in_valid nor out_ready reach it
    assign in_ready   = (r_count < CW'(DEPTH));
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == ST_IDLE) && (r_count != CW'(0));
    assign busy       = (r_state != ST_IDLE) || (r_count != CW'(0));
    assign fifo_count = r_count;

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_a      = r_out_a;
    assign out_b      = r_out_b;
    assign out_op     = r_out_op;

    // Command FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i]  <= '0;
                r_mem_b[i]  <= '0;
                r_mem_op[i] <= 3'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wr_ptr]  <= in_a;
                r_mem_b[r_wr_ptr]  <= in_b;
                r_mem_op[r_wr_ptr] <= in_op;
                r_wr_ptr           <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: pop into ALU inputs, wait out the latency, present and hold the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= 3'd0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_op     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_alu_a  <= r_mem_a[r_rd_ptr];
                        r_alu_b  <= r_mem_b[r_rd_ptr];
                        r_alu_op <= r_mem_op[r_rd_ptr];
                        r_cnt    <= CNTW'(LATENCY);
                        r_state  <= ST_WAIT;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt > CNTW'(1)) begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end else begin
                        r_out_result <= alu_o;
                        r_out_a      <= r_alu_a;
                        r_out_b      <= r_alu_b;
                        r_out_op     <= r_alu_op;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_HOLD;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-stage registered ALU stand-in
// and a scoreboard that checks every accepted result in issue order.
module tb_alu_cmd_sequencer;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [2:0]        in_op;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [2:0]        alu_op;
    logic [WIDTH-1:0]  alu_o = 32'd0;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [WIDTH-1:0]  out_a;
    logic [WIDTH-1:0]  out_b;
    logic [2:0]        out_op;
    logic              busy;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } exp_t;

    exp_t sb_q[$];
    int   rise_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    logic prev_v   = 1'b0;
    logic prev_r   = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_o(alu_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .busy(busy), .fifo_count(fifo_count)
    );

    // ALU stand-in: known IEEE-754 products for MUL, an arbitrary mix for other opcodes
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        logic [31:0] r;
        r = 32'hDEADBEEF;
        if (op == 3'b011) begin
            case ({a, b})
                {32'hA86459EA, 32'hC0B69539}: r = 32'h29A2DD08;
                {32'h17662B40, 32'hE486E07C}: r = 32'hBC7288F2;
                {32'h7CC8CC32, 32'hA30A3C30}: r = 32'hE058DA91;
                {32'h3F800000, 32'h40000000}: r = 32'h40000000;
                {32'h40400000, 32'h40800000}: r = 32'h41400000;
                default:                      r = 32'hDEADBEEF;
            endcase
        end else begin
            r = (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
        end
        return r;
    endfunction

    always @(posedge clk) alu_o <= alu_model(alu_a, alu_b, alu_op);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Output monitor: scoreboard on every handshake, hold rule, and rise times
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r) chk_value("valid_hold", 32'(out_valid), 32'd1);
            if (out_valid && !prev_v) rise_q.push_back(cyc);
            if (out_valid && out_ready) begin
                chk_value("result_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    chk_value("sb_result", out_result, sb_q[0].res);
                    chk_value("sb_a", out_a, sb_q[0].a);
                    chk_value("sb_b", out_b, sb_q[0].b);
                    chk_value("sb_op", 32'(out_op), 32'(sb_q[0].op));
                    void'(sb_q.pop_front());
                end
                n_out++;
            end
            prev_v <= out_valid;
            prev_r <= out_ready;
        end else begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] res);
        exp_t e;
        e.res = res; e.a = a; e.b = b; e.op = op;
        sb_q.push_back(e);
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [31:0] res);
        int t;
        t = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        chk_value("push_accept", 32'(in_ready), 32'd1);
        if (in_ready) begin
            @(posedge clk);
            sb_add(a, b, op, res);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while (!out_valid && t < 100);
        chk_value("valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 500) begin
            tick();
            t++;
        end
        chk_value("drain_done", 32'(sb_q.size()), 32'd0);
        chk_value("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] va[4];
        logic [31:0] vb[4];
        logic [31:0] vr[4];
        int n_edges;
        int n_before;

        va[0] = 32'h17662B40; vb[0] = 32'hE486E07C; vr[0] = 32'hBC7288F2;
        va[1] = 32'h7CC8CC32; vb[1] = 32'hA30A3C30; vr[1] = 32'hE058DA91;
        va[2] = 32'h3F800000; vb[2] = 32'h40000000; vr[2] = 32'h40000000;
        va[3] = 32'h40400000; vb[3] = 32'h40800000; vr[3] = 32'h41400000;

        rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_op = 3'd0;
        out_ready = 1'b0;
        repeat (2) tick();
        chk_value("rst_out_valid", 32'(out_valid), 32'd0);
        chk_value("rst_in_ready", 32'(in_ready), 32'd1);
        chk_value("rst_busy", 32'(busy), 32'd0);
        chk_value("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk_value("rst_alu_a", alu_a, 32'd0);
        chk_value("rst_alu_op", 32'(alu_op), 32'd0);
        chk_value("rst_out_result", out_result, 32'd0);
        chk_value("rst_out_op", 32'(out_op), 32'd0);
        rst = 1'b0;
        tick();

        // Single MUL; latency counted with the push edge as the first edge
        out_ready = 1'b1;
        in_a = 32'hA86459EA; in_b = 32'hC0B69539; in_op = 3'b011; in_valid = 1'b1;
        @(posedge clk);
        sb_add(32'hA86459EA, 32'hC0B69539, 3'b011, 32'h29A2DD08);
        #1;
        in_valid = 1'b0;
        n_edges = 1;
        while (!out_valid && n_edges < 20) begin
            tick();
            n_edges++;
        end
        chk_value("mul_latency", 32'(n_edges), 32'(LATENCY + 2));
        chk_value("mul_result", out_result, 32'h29A2DD08);
        chk_value("mul_out_a", out_a, 32'hA86459EA);
        chk_value("mul_out_b", out_b, 32'hC0B69539);
        chk_value("mul_out_op", 32'(out_op), 32'd3);
        drain();

        // Burst of four MULs, out_ready high
        rise_q.delete();
        for (int i = 0; i < 4; i++) begin
            chk_value("burst_in_ready", 32'(in_ready), 32'd1);
            push_cmd(va[i], vb[i], 3'b011, vr[i]);
        end
        drain();
        chk_value("burst_results", 32'(rise_q.size()), 32'd4);
        for (int i = 1; i < rise_q.size(); i++)
            chk_value("burst_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'(LATENCY + 2));

        // Full FIFO with out_ready low, mixed opcodes including undefined ones
        out_ready = 1'b0;
        n_before = n_out;
        push_cmd(32'h00000011, 32'h00002200, 3'b000, alu_model(32'h00000011, 32'h00002200, 3'b000));
        push_cmd(32'hFFFF0000, 32'h12345678, 3'b111, alu_model(32'hFFFF0000, 32'h12345678, 3'b111));
        push_cmd(32'h0F0F0F0F, 32'hF0F0F0F0, 3'b101, alu_model(32'h0F0F0F0F, 32'hF0F0F0F0, 3'b101));
        push_cmd(32'h3F800000, 32'h40000000, 3'b011, 32'h40000000);
        push_cmd(32'hCAFEBABE, 32'h0BADF00D, 3'b110, alu_model(32'hCAFEBABE, 32'h0BADF00D, 3'b110));
        chk_value("full_in_ready", 32'(in_ready), 32'd0);
        chk_value("full_count", 32'(fifo_count), 32'(DEPTH));
        in_a = 32'h55AA55AA; in_b = 32'hAA55AA55; in_op = 3'b100; in_valid = 1'b1;
        repeat (3) tick();
        chk_value("full_6th_blocked", 32'(in_ready), 32'd0);
        chk_value("full_6th_count", 32'(fifo_count), 32'(DEPTH));
        out_ready = 1'b1;
        push_cmd(32'h55AA55AA, 32'hAA55AA55, 3'b100, alu_model(32'h55AA55AA, 32'hAA55AA55, 3'b100));
        drain();
        chk_value("full_drain_count", 32'(n_out - n_before), 32'd6);

        // Backpressure: ten cycles in HOLD with another command queued
        out_ready = 1'b0;
        push_cmd(32'h40400000, 32'h40800000, 3'b011, 32'h41400000);
        push_cmd(32'h00001234, 32'h00005678, 3'b001, alu_model(32'h00001234, 32'h00005678, 3'b001));
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_value("bp_valid", 32'(out_valid), 32'd1);
            chk_value("bp_result", out_result, 32'h41400000);
            chk_value("bp_alu_a", alu_a, 32'h40400000);
            chk_value("bp_count", 32'(fifo_count), 32'd1);
        end
        out_ready = 1'b1;
        drain();

        // Reset in the middle of WAIT discards everything
        push_cmd(32'h17662B40, 32'hE486E07C, 3'b011, 32'hBC7288F2);
        push_cmd(32'h7CC8CC32, 32'hA30A3C30, 3'b011, 32'hE058DA91);
        tick();
        rst = 1'b1;
        #1;
        chk_value("mrst_out_valid", 32'(out_valid), 32'd0);
        chk_value("mrst_alu_a", alu_a, 32'd0);
        chk_value("mrst_out_a", out_a, 32'd0);
        chk_value("mrst_busy", 32'(busy), 32'd0);
        chk_value("mrst_count", 32'(fifo_count), 32'd0);
        chk_value("mrst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        tick();
        rst = 1'b0;
        n_before = n_out;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_value("mrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk_value("mrst_count_after", 32'(fifo_count), 32'd0);
        chk_value("mrst_no_output", 32'(n_out - n_before), 32'd0);

        // Push and pop on the same edge at count 2
        out_ready = 1'b0;
        push_cmd(32'h00000001, 32'h00000002, 3'b010, alu_model(32'h00000001, 32'h00000002, 3'b010));
        push_cmd(32'h00000003, 32'h00000004, 3'b010, alu_model(32'h00000003, 32'h00000004, 3'b010));
        push_cmd(32'h00000005, 32'h00000006, 3'b010, alu_model(32'h00000005, 32'h00000006, 3'b010));
        wait_valid();
        chk_value("pp_count_hold", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
        tick();
        chk_value("pp_count_idle", 32'(fifo_count), 32'd2);
        in_a = 32'h00000007; in_b = 32'h00000008; in_op = 3'b010; in_valid = 1'b1;
        @(posedge clk);
        sb_add(32'h00000007, 32'h00000008, 3'b010, alu_model(32'h00000007, 32'h00000008, 3'b010));
        #1;
        in_valid = 1'b0;
        chk_value("pp_count_same", 32'(fifo_count), 32'd2);
        chk_value("pp_oldest_a", alu_a, 32'h00000003);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
